// File: rtl/riscvibe_pkg.sv
// Shared types and constants for the riscvibe core front end.
package riscvibe_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int          FETCH_FIFO_DEPTH_DEFAULT = 4;
    localparam logic [31:0] INSTR_NOP                = 32'h00000013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; the head is read straight from
// the storage flops, so a pushed entry becomes visible the cycle after the push.
module fetch_fifo
    import riscvibe_pkg::*;
#(
    parameter int DEPTH = FETCH_FIFO_DEPTH_DEFAULT,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output logic         out_valid,
    output fetch_entry_t out_data,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch stage: owns the PC, issues in-order imem requests under a credit limit,
// tags responses with their PC, drops stale ones after a redirect, and buffers the rest.
module fetch_controller
    import riscvibe_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000,
    parameter int          FIFO_DEPTH   = FETCH_FIFO_DEPTH_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              fetch_enable,
    input  logic                              redirect_valid,
    input  logic [31:0]                       redirect_pc,
    output logic                              imem_req,
    output logic [31:0]                       imem_addr,
    input  logic                              imem_gnt,
    input  logic                              imem_rvalid,
    input  logic [31:0]                       imem_rdata,
    output logic                              if_valid,
    output logic [31:0]                       if_pc,
    output logic [31:0]                       if_instr,
    input  logic                              if_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   outstanding
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] kill_cnt_q, kill_cnt_d;
    logic [CW-1:0] tag_count, buf_count;
    fetch_entry_t  tag_head, buf_head;
    logic          tag_full, tag_empty, buf_full, buf_empty;
    logic          credit_ok, issue, resp, killed, buf_push, buf_pop;
    logic          unused_sigs;

    // Outstanding plus buffered entries never exceed the buffer depth, so every
    // response in flight is guaranteed a slot.
    assign credit_ok = ({1'b0, tag_count} + {1'b0, buf_count}) < (CW+1)'(FIFO_DEPTH);
    assign imem_req  = fetch_enable && !redirect_valid && credit_ok;
    assign imem_addr = pc_q;
    assign issue     = imem_req && imem_gnt;

    assign resp     = imem_rvalid && (tag_count != '0);
    assign killed   = resp && (kill_cnt_q != '0);
    assign buf_push = resp && !killed && !redirect_valid;
    assign buf_pop  = if_valid && if_ready;

    always_comb begin
        pc_d       = pc_q;
        kill_cnt_d = kill_cnt_q;
        if (redirect_valid) begin
            pc_d       = {redirect_pc[31:2], 2'b00};
            kill_cnt_d = tag_count - CW'(resp);
        end else begin
            if (issue) begin
                pc_d = pc_q + 32'd4;
            end
            if (killed) begin
                kill_cnt_d = kill_cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_VECTOR;
            kill_cnt_q <= '0;
        end else begin
            pc_q       <= pc_d;
            kill_cnt_q <= kill_cnt_d;
        end
    end

    // The tag queue is never flushed: killed requests still return and must be matched.
    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_tag_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .push      (issue),
        .push_data ('{pc: pc_q, instr: 32'h0}),
        .pop       (resp),
        .out_valid (),
        .out_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_instr_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (buf_push),
        .push_data ('{pc: tag_head.pc, instr: imem_rdata}),
        .pop       (buf_pop),
        .out_valid (if_valid),
        .out_data  (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    assign if_pc       = buf_head.pc;
    assign if_instr    = buf_head.instr;
    assign outstanding = tag_count;
    assign unused_sigs = ^{redirect_pc[1:0], tag_head.instr, tag_full, tag_empty, buf_empty};

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(imem_rvalid && tag_count == '0));
            assert (!(buf_push && buf_full && !buf_pop));
            assert (kill_cnt_q <= tag_count);
        end
    end
`endif

endmodule
